// File: rtl/pipe_pkg.sv
// Shared types for the hazard controller: operand source codes and
// the per-stage writer record tracked in EX, MEM and WB.
package pipe_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] waddr;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // Register 0 is hardwired, so it can never be a hazard source.
    function automatic logic slot_hit(slot_t s, logic [4:0] a);
        return s.valid && (s.waddr == a) && (a != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard query bundle: master is the decode side,
// slave is the hazard controller answering with stall/forward controls.
interface pipe_hazard_ctrl_if;
    import pipe_pkg::*;

    logic        id_valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_used;
    logic        rt_used;
    logic [4:0]  rd_waddr;
    logic        rd_wena;
    logic        is_load;
    logic        branch_taken;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [31:0] stall_count;

    modport master (
        output id_valid, rs_addr, rt_addr, rs_used, rt_used,
        output rd_waddr, rd_wena, is_load, branch_taken,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        input  fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_valid, rs_addr, rt_addr, rs_used, rt_used,
        input  rd_waddr, rd_wena, is_load, branch_taken,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        output fwd_a_sel, fwd_b_sel, stall_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / RAW hazard controller for a 5-stage pipe.
// Define PIPE_HAZARD_FORWARD_EN to enable EX/MEM forwarding.
module pipe_hazard_ctrl
    import pipe_pkg::*;
(
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_id_valid,
    input  logic [4:0]  in_id_rs_addr,
    input  logic [4:0]  in_id_rt_addr,
    input  logic        in_id_rs_used,
    input  logic        in_id_rt_used,
    input  logic [4:0]  in_id_rd_waddr,
    input  logic        in_id_rd_wena,
    input  logic        in_id_is_load,
    input  logic        in_ex_branch_taken,
    output logic        out_pc_stall,
    output logic        out_if_id_stall,
    output logic        out_if_id_flush,
    output logic        out_id_ex_bubble,
    output logic [1:0]  out_fwd_a_sel,
    output logic [1:0]  out_fwd_b_sel,
    output logic [31:0] out_stall_count
);

    slot_t       ex_q, ex_d, mem_q, wb_q;
    logic [31:0] cnt_q, cnt_d;

    logic id_valid, branch;
    logic a_ex, a_mem, b_ex, b_mem;
    logic need_a, need_b, stall;
    logic [1:0] fwd_a, fwd_b;
    logic unused_wb;

    // Gating with reset keeps every control quiet while held in reset.
    assign id_valid = in_id_valid & in_rst_n;
    assign branch   = in_ex_branch_taken & in_rst_n;

    assign a_ex  = in_id_rs_used & id_valid & slot_hit(ex_q, in_id_rs_addr);
    assign a_mem = in_id_rs_used & id_valid & slot_hit(mem_q, in_id_rs_addr);
    assign b_ex  = in_id_rt_used & id_valid & slot_hit(ex_q, in_id_rt_addr);
    assign b_mem = in_id_rt_used & id_valid & slot_hit(mem_q, in_id_rt_addr);

`ifdef PIPE_HAZARD_FORWARD_EN
    // A load in EX has no data yet: wait one cycle, then take it from MEM.
    always_comb begin
        need_a = a_ex & ex_q.is_load;
        need_b = b_ex & ex_q.is_load;
        fwd_a  = FWD_REG;
        fwd_b  = FWD_REG;
        if (a_ex) begin
            fwd_a = ex_q.is_load ? FWD_REG : FWD_EX;
        end else if (a_mem) begin
            fwd_a = FWD_MEM;
        end
        if (b_ex) begin
            fwd_b = ex_q.is_load ? FWD_REG : FWD_EX;
        end else if (b_mem) begin
            fwd_b = FWD_MEM;
        end
    end
`else
    always_comb begin
        need_a = a_ex | a_mem;
        need_b = b_ex | b_mem;
        fwd_a  = FWD_REG;
        fwd_b  = FWD_REG;
    end
`endif

    assign stall = (need_a | need_b) & ~branch;

    assign out_pc_stall     = stall;
    assign out_if_id_stall  = stall;
    assign out_if_id_flush  = branch;
    assign out_id_ex_bubble = stall | branch;
    assign out_fwd_a_sel    = fwd_a;
    assign out_fwd_b_sel    = fwd_b;
    assign out_stall_count  = cnt_q;

    always_comb begin
        ex_d = SLOT_EMPTY;
        if (!stall && !branch) begin
            ex_d.valid   = in_id_valid & in_id_rd_wena
                         & (in_id_rd_waddr != 5'd0);
            ex_d.waddr   = in_id_rd_waddr;
            ex_d.is_load = in_id_is_load;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    // WB writes the regfile in the first half-cycle, so it never hazards.
    assign unused_wb = ^wb_q;

endmodule
